// File: rtl/uart_tx_frame.sv
// uart_tx_frame: 8N1 serial transmitter.
// Sends a start bit (0), eight data bits LSB-first, then a stop bit (1).
// Every bit is held for CLKS_PER_BIT clocks. All outputs come from flops.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [2:0]       idx, idx_nx;
  logic [7:0]       shift, shift_nx;
  logic             out_nx, busy_nx, done_nx;
  logic             term;

  assign term = (cnt == CNT_LAST);

  // State, datapath and output registers; reset forces an idle-high line.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      shift   <= '0;
      tx_out  <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      idx     <= idx_nx;
      shift   <= shift_nx;
      tx_out  <= out_nx;
      tx_busy <= busy_nx;
      tx_done <= done_nx;
    end
  end

  // Next-state, bit timing and shift control. The output values are derived
  // from the next state so that the registered outputs line up with the state.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    idx_nx   = idx;
    shift_nx = shift;
    done_nx  = 1'b0;

    case (state)
      IDLE: begin
        if (tx_start) begin
          shift_nx = tx_data;
          cnt_nx   = '0;
          idx_nx   = '0;
          state_nx = START;
        end
      end
      START: begin
        if (term) begin
          cnt_nx   = '0;
          state_nx = DATA;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      DATA: begin
        if (term) begin
          cnt_nx   = '0;
          shift_nx = {1'b0, shift[7:1]};
          idx_nx   = idx + 3'd1;
          if (idx == 3'd7) begin
            state_nx = STOP;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      STOP: begin
        if (term) begin
          cnt_nx   = '0;
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase

    case (state_nx)
      START:   out_nx = 1'b0;
      DATA:    out_nx = shift_nx[0];
      default: out_nx = 1'b1;
    endcase
    busy_nx = (state_nx != IDLE);
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// tb_uart_tx_frame: self-checking bench for uart_tx_frame.
// A frame-level model predicts the line, busy and done every cycle from the
// number of clocks elapsed since the accepted start strobe.
module tb_uart_tx_frame;

  localparam int C     = 10;
  localparam int FRAME = 10 * C;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  bit         m_active = 1'b0;
  int         m_p      = 0;
  logic [7:0] m_byte   = 8'h00;
  int         done_seen = 0;

  uart_tx_frame #(.CLKS_PER_BIT(C)) dut (
    .clk      (clk),
    .rst      (rst),
    .tx_start (tx_start),
    .tx_data  (tx_data),
    .tx_out   (tx_out),
    .tx_busy  (tx_busy),
    .tx_done  (tx_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Apply inputs for one clock, advance the model, then compare outputs.
  task automatic step(input bit s, input logic [7:0] d);
    logic [9:0] fr;
    logic       e_out, e_busy, e_done;
    tx_start = s;
    tx_data  = d;
    @(posedge clk);
    if (rst) begin
      m_active = 1'b0;
    end else if ((!m_active || m_p == FRAME) && s) begin
      m_active = 1'b1;
      m_p      = 0;
      m_byte   = d;
    end else if (m_active) begin
      m_p++;
      if (m_p > FRAME) m_active = 1'b0;
    end
    #1;
    fr = {1'b1, m_byte, 1'b0};
    if (m_active && m_p < FRAME) begin
      e_out = fr[m_p / C]; e_busy = 1'b1; e_done = 1'b0;
    end else if (m_active) begin
      e_out = 1'b1; e_busy = 1'b0; e_done = 1'b1;
    end else begin
      e_out = 1'b1; e_busy = 1'b0; e_done = 1'b0;
    end
    check("tx_out",  {31'd0, tx_out},  {31'd0, e_out});
    check("tx_busy", {31'd0, tx_busy}, {31'd0, e_busy});
    check("tx_done", {31'd0, tx_done}, {31'd0, e_done});
    if (tx_done === 1'b1) done_seen++;
  endtask

  // Independent mid-bit sampling receiver: start bit, 8 data bits, stop bit.
  task automatic rx_frame(output logic [7:0] b, output logic stop);
    int n = 0;
    b = 8'h00;
    stop = 1'b0;
    while (tx_out !== 1'b0 && n < 40) begin
      step(1'b0, 8'($urandom));
      n++;
    end
    check("rx_start_seen", {31'd0, (n < 40)}, 32'd1);
    repeat (C / 2) step(1'b0, 8'($urandom));
    for (int i = 0; i < 9; i++) begin
      repeat (C) step(1'b0, 8'($urandom));
      if (i < 8) b[i] = tx_out;
      else       stop = tx_out;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) step(1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic [7:0] lb_bytes [4];
    int         d0;

    rst = 1'b1;
    tx_start = 1'b0;
    tx_data = 8'h00;

    // Reset then idle.
    repeat (3) step(1'b0, 8'h00);
    rst = 1'b0;
    idle_cycles(50);

    // Single byte 0xA5.
    d0 = done_seen;
    step(1'b1, 8'hA5);
    rx_frame(rb, rs);
    check("a5_data", {24'd0, rb}, 32'hA5);
    check("a5_stop", {31'd0, rs}, 32'd1);
    idle_cycles(20);
    check("a5_done_count", done_seen - d0, 32'd1);

    // Back-to-back: start held, re-accepted in each done cycle.
    d0 = done_seen;
    step(1'b1, 8'h00);
    repeat (2 * FRAME + 10) step(1'b1, 8'hFF);
    idle_cycles(FRAME + 10);
    check("b2b_done_count", done_seen - d0, 32'd3);

    // Busy rejection: a second strobe and data changes mid-frame are ignored.
    d0 = done_seen;
    step(1'b1, 8'h3C);
    repeat (39) step(1'b0, 8'($urandom));
    step(1'b1, 8'h81);
    repeat (FRAME) step(1'b0, 8'($urandom));
    check("busy_done_count", done_seen - d0, 32'd1);
    idle_cycles(5);

    // Reset mid-frame: line returns high at once, no done for the lost frame.
    d0 = done_seen;
    step(1'b1, 8'h55);
    repeat (34) step(1'b0, 8'h55);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_out",  {31'd0, tx_out},  32'd1);
    check("async_rst_busy", {31'd0, tx_busy}, 32'd0);
    m_active = 1'b0;
    repeat (2) step(1'b0, 8'h00);
    rst = 1'b0;
    step(1'b1, 8'h12);
    rx_frame(rb, rs);
    check("post_rst_data", {24'd0, rb}, 32'h12);
    check("post_rst_stop", {31'd0, rs}, 32'd1);
    idle_cycles(10);
    check("rst_done_count", done_seen - d0, 32'd1);

    // Loopback through the behavioural receiver.
    lb_bytes[0] = 8'h00; lb_bytes[1] = 8'hFF; lb_bytes[2] = 8'h5A; lb_bytes[3] = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      step(1'b1, lb_bytes[k]);
      rx_frame(rb, rs);
      check("loop_data", {24'd0, rb}, {24'd0, lb_bytes[k]});
      check("loop_stop", {31'd0, rs}, 32'd1);
      idle_cycles(8);
    end

    // Randomized traffic with occasional resets.
    for (int t = 0; t < 3000; t++) begin
      rst = ($urandom_range(0, 599) == 0);
      step(($urandom_range(0, 29) == 0), 8'($urandom));
    end
    rst = 1'b0;
    idle_cycles(FRAME + 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
